// File: rtl/uart_tx.sv
// Serial transmitter: accepts a parallel word when idle and sends start bit,
// DW data bits LSB first, optional even parity bit and stop bit, BAUD_DIV clocks each.
module uart_tx #(
    parameter int DW       = 8,
    parameter int BAUD_DIV = 16,
    parameter int PAR_EN   = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] i_data,
    input  logic          i_valid,
    output logic          o_ready,
    output logic          o_tx,
    output logic          o_busy,
    output logic          o_done,
    output logic [2:0]    o_dbg_state
);

    localparam int BW = $clog2(BAUD_DIV);
    localparam int CW = $clog2(DW);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DW - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [CW-1:0]   bit_q, bit_d;
    logic [DW-1:0]   shift_q, shift_d;
    logic            par_q, par_d;
    logic            tx_q, tx_d;
    logic            done_q, done_d;
    logic            baud_last;

    assign baud_last = (baud_q == BAUD_LAST);

    // Handshake: a word transfers on a rising edge where i_valid && o_ready;
    // o_ready is high only in IDLE, and i_valid is ignored in every other state.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (i_valid) begin
                    state_d = START;
                    shift_d = i_data;
                    par_d   = ^i_data;
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (baud_last) begin
                    state_d = DATA;
                    baud_d  = '0;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == BIT_LAST) begin
                        if (PAR_EN != 0) begin
                            state_d = PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        // tx takes the bit that becomes shift_q[0] after the shift
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            PARITY: begin
                if (baud_last) begin
                    state_d = STOP;
                    baud_d  = '0;
                    tx_d    = 1'b1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_last) begin
                    state_d = IDLE;
                    baud_d  = '0;
                    tx_d    = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign o_ready     = (state_q == IDLE);
    assign o_busy      = ~o_ready;
    assign o_tx        = tx_q;
    assign o_done      = done_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (no parity / even parity) share clock and reset;
// a line monitor per instance decodes frames and compares them with a frame model.
module tb_uart_tx;

    localparam int DW = 8;
    localparam int B  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  valid_w = '0;
    logic [15:0] data_w = '0;
    logic [1:0]  ready_w, tx_w, busy_w, done_w;
    logic [2:0]  st0, st1;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    int gap_w[2];
    int frames_w[2];
    int exp_frames[2];

    always #5 clk = ~clk;

    uart_tx #(.DW(DW), .BAUD_DIV(B), .PAR_EN(0)) u_dut0 (
        .clk(clk), .rst(rst), .i_data(data_w[7:0]), .i_valid(valid_w[0]),
        .o_ready(ready_w[0]), .o_tx(tx_w[0]), .o_busy(busy_w[0]), .o_done(done_w[0]),
        .o_dbg_state(st0)
    );

    uart_tx #(.DW(DW), .BAUD_DIV(B), .PAR_EN(1)) u_dut1 (
        .clk(clk), .rst(rst), .i_data(data_w[15:8]), .i_valid(valid_w[1]),
        .o_ready(ready_w[1]), .o_tx(tx_w[1]), .o_busy(busy_w[1]), .o_done(done_w[1]),
        .o_dbg_state(st1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Line levels of one frame, one entry per bit period, start bit first.
    function automatic logic [11:0] model_frame(input logic [7:0] w, input int p);
        logic [11:0] f;
        int n;
        f = '0;
        n = 0;
        f[n] = 1'b0;
        n++;
        for (int i = 0; i < DW; i++) begin
            f[n] = w[i];
            n++;
        end
        if (p != 0) begin
            f[n] = (($countones(w) % 2) == 1);
            n++;
        end
        f[n] = 1'b1;
        return f;
    endfunction

    task automatic push_exp(input int d, input logic [7:0] w);
        if (d == 0) exp_q0.push_back(w);
        else exp_q1.push_back(w);
        exp_frames[d]++;
    endtask

    task automatic monitor(input int d);
        int nb;
        int idle_run;
        bit done_due;
        bit aborted;
        bit hs_bad;
        bit steady;
        bit have;
        logic [63:0] samp;
        logic [11:0] got;
        logic [7:0] e;
        nb = 2 + DW + d;
        idle_run = 0;
        done_due = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                done_due = 0;
                idle_run = 0;
                continue;
            end
            chk($sformatf("done_%0d", d), {31'd0, done_w[d]}, {31'd0, done_due});
            done_due = 0;
            if (tx_w[d] === 1'b1) begin
                chk($sformatf("idle_ready_%0d", d), {30'd0, ready_w[d], busy_w[d]}, 32'd2);
                idle_run++;
                continue;
            end
            gap_w[d] = idle_run;
            aborted = 0;
            hs_bad = 0;
            samp = '0;
            for (int k = 0; k < nb * B; k++) begin
                if (k > 0) @(negedge clk);
                if (!rst) begin
                    aborted = 1;
                    break;
                end
                samp[k] = tx_w[d];
                if (ready_w[d] !== 1'b0 || busy_w[d] !== 1'b1 || done_w[d] !== 1'b0) hs_bad = 1;
            end
            idle_run = 0;
            if (aborted) continue;
            got = '0;
            for (int b = 0; b < nb; b++) begin
                steady = 1;
                for (int c = 1; c < B; c++)
                    if (samp[b*B+c] !== samp[b*B]) steady = 0;
                chk($sformatf("bit_steady_%0d_b%0d", d, b), {31'd0, steady}, 32'd1);
                got[b] = samp[b*B];
            end
            chk($sformatf("frame_handshake_%0d", d), {31'd0, hs_bad}, 32'd0);
            have = (d == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
            if (!have) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_frame_%0d: got levels %0h expected none", d, got);
            end else begin
                if (d == 0) e = exp_q0.pop_front();
                else e = exp_q1.pop_front();
                chk($sformatf("frame_bits_%0d", d), {20'd0, got}, {20'd0, model_frame(e, d)});
            end
            frames_w[d]++;
            done_due = 1;
        end
    endtask

    task automatic send(input int d, input logic [7:0] w);
        int t;
        t = 0;
        @(negedge clk);
        while (ready_w[d] !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("ready_wait_%0d", d), {31'd0, ready_w[d]}, 32'd1);
        data_w[d*8 +: 8] = w;
        valid_w[d] = 1'b1;
        push_exp(d, w);
        @(posedge clk);
        #1;
        chk($sformatf("accept_latency_%0d", d), {30'd0, tx_w[d], busy_w[d]}, 32'd1);
        valid_w[d] = 1'b0;
        data_w[d*8 +: 8] = 8'($urandom);
    endtask

    task automatic wait_idle(input int d);
        int t;
        bit empty;
        t = 0;
        empty = 0;
        while (t < 3000) begin
            @(negedge clk);
            empty = (d == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
            if (empty && ready_w[d] === 1'b1) break;
            t++;
        end
        chk($sformatf("idle_timeout_%0d", d), {31'd0, empty}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        gap_w = '{0, 0};
        frames_w = '{0, 0};
        exp_frames = '{0, 0};
        fork
            monitor(0);
            monitor(1);
        join_none

        // Reset held low: line idle, ready, no done.
        repeat (5) begin
            @(negedge clk);
            chk("rst_outputs_0", {28'd0, tx_w[0], ready_w[0], busy_w[0], done_w[0]}, 32'hC);
            chk("rst_outputs_1", {28'd0, tx_w[1], ready_w[1], busy_w[1], done_w[1]}, 32'hC);
        end
        chk("rst_state_0", {29'd0, st0}, 32'd0);
        chk("rst_state_1", {29'd0, st1}, 32'd0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Basic frame without parity, then parity frames.
        send(0, 8'hA5);
        wait_idle(0);
        send(1, 8'hA5);
        send(1, 8'h07);
        wait_idle(1);

        // Back-to-back with i_valid held high.
        @(negedge clk);
        data_w[7:0] = 8'h55;
        valid_w[0] = 1'b1;
        push_exp(0, 8'h55);
        @(posedge clk);
        #1;
        data_w[7:0] = 8'hFF;
        push_exp(0, 8'hFF);
        begin
            int t;
            t = 0;
            @(negedge clk);
            while (ready_w[0] !== 1'b1 && t < 200) begin
                @(negedge clk);
                t++;
            end
        end
        chk("b2b_done_with_ready", {30'd0, done_w[0], ready_w[0]}, 32'd3);
        @(posedge clk);
        #1;
        valid_w[0] = 1'b0;
        chk("b2b_second_start", {31'd0, tx_w[0]}, 32'd0);
        wait_idle(0);
        chk("b2b_gap", gap_w[0], 32'd1);

        // Busy ignore: offer 0x00 mid-frame.
        send(1, 8'h3C);
        repeat (10) @(negedge clk);
        data_w[15:8] = 8'h00;
        valid_w[1] = 1'b1;
        chk("busy_not_ready", {30'd0, ready_w[1], busy_w[1]}, 32'd1);
        @(negedge clk);
        valid_w[1] = 1'b0;
        wait_idle(1);
        repeat (50) @(negedge clk);

        // Reset during data bit 3, then accept on first edge after release.
        send(0, 8'h96);
        repeat (4 + 3 * B + 1) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_outputs", {28'd0, tx_w[0], ready_w[0], busy_w[0], done_w[0]}, 32'hC);
        exp_q0.delete();
        exp_frames[0]--;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        data_w[7:0] = 8'h81;
        valid_w[0] = 1'b1;
        push_exp(0, 8'h81);
        @(posedge clk);
        #1;
        chk("post_rst_accept", {31'd0, tx_w[0]}, 32'd0);
        valid_w[0] = 1'b0;
        wait_idle(0);

        // Randomized words with random spacing on both instances.
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 12; n++) begin
                repeat ($urandom_range(0, 5)) @(negedge clk);
                send(d, 8'($urandom));
            end
            wait_idle(d);
        end

        repeat (5) @(negedge clk);
        chk("queue_empty_0", exp_q0.size(), 32'd0);
        chk("queue_empty_1", exp_q1.size(), 32'd0);
        chk("frame_count_0", frames_w[0], exp_frames[0]);
        chk("frame_count_1", frames_w[1], exp_frames[1]);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DW, default 8, data bits per frame (5..9).
REQ-002 SHALL have parameter BAUD_DIV, default 16, clk cycles per serial bit (>=2).
REQ-003 SHALL have parameter PAR_EN, default 0, 1 = even parity bit inserted after data.
REQ-004 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_data  input  DW  parallel word to transmit.
REQ-007 SHALL have port i_valid  input  1  word on i_data offered.
REQ-008 SHALL have port o_ready  output  1  transmitter can accept a word.
REQ-009 SHALL have port o_tx  output  1  serial line, idle high.
REQ-010 SHALL have port o_busy  output  1  frame in progress.
REQ-011 SHALL have port o_done  output  1  one-cycle pulse, frame completed.

Function
REQ-012 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-013 SHALL assert o_ready only in IDLE; o_busy SHALL equal NOT o_ready.
REQ-014 SHALL accept a word when i_valid && o_ready at a clk edge: capture i_data into internal shift register, enter START.
REQ-015 SHALL ignore i_valid in all states other than IDLE; i_data changes after acceptance SHALL not affect the frame.
REQ-016 SHALL drive o_tx registered: 1 in IDLE and STOP, 0 in START, shift register bit 0 in DATA, parity bit in PARITY.
REQ-017 SHALL hold each of START, each data bit, PARITY, STOP for exactly BAUD_DIV cycles via a baud counter 0..BAUD_DIV-1 reset on every state/bit change.
REQ-018 SHALL transmit data LSB first; shift register SHALL shift right by one at each data-bit boundary.
REQ-019 SHALL count data bits with a bit counter 0..DW-1; after bit DW-1 go to PARITY if PAR_EN=1 else STOP.
REQ-020 SHALL compute parity as XOR of the captured word (even parity: total ones incl. parity bit even).
REQ-021 SHALL leave STOP after BAUD_DIV cycles, enter IDLE, and assert o_done for exactly the first IDLE cycle.
REQ-022 SHALL allow a new word to be accepted in that same first IDLE cycle (o_done and o_ready both high); the next start bit then follows with no extra idle gap beyond one cycle.
REQ-023 SHALL give first o_tx=0 on the clk edge after acceptance (1-cycle latency); total frame = (2+DW+PAR_EN)*BAUD_DIV cycles.
REQ-024 SHALL never produce glitches or partial bits: each o_tx level persists a whole BAUD_DIV period.

Reset
REQ-025 SHALL, on rst low, immediately force: state IDLE, o_tx=1, o_ready=1, o_busy=0, o_done=0, counters and shift register 0.
REQ-026 SHALL abort any frame in progress on reset mid-frame; line returns high asynchronously, no o_done issued.
REQ-027 SHALL accept a word on the first clk edge after rst release if i_valid high.

Verification
REQ-028 Reset idle: hold rst low 5 cycles then release, i_valid=0 -> o_tx=1, o_ready=1, o_busy=0, o_done=0 throughout.
REQ-029 Basic frame, DW=8, BAUD_DIV=4, PAR_EN=0, send 0xA5 -> o_tx sequence per 4 cycles: 0,1,0,1,0,0,1,0,1,1; o_done pulse 40 cycles after acceptance edge.
REQ-030 Parity, PAR_EN=1, send 0xA5 then 0x07 -> parity bits 0 then 1; frames 44 cycles each.
REQ-031 Back-to-back: i_valid held high with 0x55 then 0xFF -> second word accepted in o_done cycle, single idle-high cycle between stop and next start.
REQ-032 Busy ignore: pulse i_valid with 0x00 mid-frame of 0x3C -> 0x3C transmitted intact, 0x00 never sent.
REQ-033 Reset mid-frame: assert rst during DATA bit 3 -> o_tx=1 immediately, no o_done; after release, 0x81 sends correctly.
